ms_timer_arbiter: RTL and testbench

Shared millisecond delay timer for the 1 MHz clock domain, with round-robin arbitration between NREQ requesters. Each requester asks for a delay of N milliseconds. The block grants the single timer to one requester at a time, counts 1 ms ticks from an internal prescaler, and pulses `done` for the owner when the delay expires. It replaces per-module divider/counter pairs wherever several blocks need millisecond waits.

---
 rtl/ms_timer_arbiter.sv | 126 ++++++++++++
 tb/tb_ms_timer_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ms_timer_arbiter.sv
// Shared millisecond delay timer with round-robin arbitration between NREQ requesters.
// Define MSARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ms_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int DIV  = 1000,
    parameter int DIVW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] dly,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              tick
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = IW + 1;
    localparam logic [DIVW-1:0] PRESC_LAST = DIVW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   own;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_next;
    logic [DW-1:0]   rem;
    logic [DIVW-1:0] presc;
    logic [NREQ-1:0] gnt_reg;
    logic [NREQ-1:0] done_reg;

    logic [IW-1:0]   sel;
    logic            sel_valid;
    logic [SW-1:0]   scan_idx;
    logic [DW-1:0]   sel_dly;
    logic [NREQ-1:0] sel_onehot;
    logic [NREQ-1:0] own_onehot;

    // Scan downward in offset so the entry closest to ptr is the last (winning) assignment.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        scan_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + SW'(k);
            if (scan_idx >= SW'(NREQ))
                scan_idx = scan_idx - SW'(NREQ);
            if (req[scan_idx[IW-1:0]]) begin
                sel       = scan_idx[IW-1:0];
                sel_valid = 1'b1;
            end
        end
    end

    assign sel_dly = dly[int'(sel)*DW +: DW];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel == IW'(gi));
            assign own_onehot[gi] = (own == IW'(gi));
        end
    endgenerate

`ifdef MSARB_FIXED_PRIO_EN
    assign ptr_next = '0;
`else
    assign ptr_next = (own == IW'(NREQ - 1)) ? '0 : own + 1'b1;
`endif

    assign tick = (presc == PRESC_LAST);
    assign busy = (state != IDLE);
    assign gnt  = gnt_reg;
    assign done = done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            own      <= '0;
            ptr      <= '0;
            rem      <= '0;
            presc    <= '0;
            gnt_reg  <= '0;
            done_reg <= '0;
        end else begin
            done_reg <= '0;
            presc    <= tick ? '0 : presc + 1'b1;
            case (state)
                IDLE: begin
                    // A zero delay parks in RUN with rem==0 for one cycle so done lands one cycle after gnt.
                    if (sel_valid) begin
                        own     <= sel;
                        rem     <= sel_dly;
                        presc   <= '0;
                        gnt_reg <= sel_onehot;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (!req[own]) begin
                        state   <= IDLE;
                        gnt_reg <= '0;
                        ptr     <= ptr_next;
                    end else if (rem == '0) begin
                        state    <= DONE;
                        done_reg <= own_onehot;
                    end else if (tick) begin
                        rem <= rem - 1'b1;
                        if (rem == DW'(1)) begin
                            state    <= DONE;
                            done_reg <= own_onehot;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    gnt_reg <= '0;
                    ptr     <= ptr_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ms_timer_arbiter.sv
// Directed bench for ms_timer_arbiter with DIV=10: grant latency, delays, contention,
// fairness, zero delay, abort and asynchronous reset in mid-run.
module tb_ms_timer_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] dly;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic              tick;

    int vectors    = 0;
    int miscompares = 0;
    int n;
    logic [NREQ-1:0] exp_own;

    ms_timer_arbiter #(.NREQ(NREQ), .DW(DW), .DIV(10), .DIVW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dly   (dly),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        while (gnt == '0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done == '0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic set_dly(input int idx, input logic [DW-1:0] v);
        dly[idx*DW +: DW] = v;
    endtask

    initial begin
        req   = '0;
        dly   = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_gnt",  32'(gnt),  32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // Contention: 0 and 2 together, ptr starts at 0
        set_dly(0, 16'd2);
        set_dly(2, 16'd2);
        req = 4'b0101;
        wait_gnt(n);
        check("cont_lat0", 32'(n), 32'd1);
        check("cont_gnt0", 32'(gnt), 32'h1);
        wait_done(n);
        check("cont_dly0", 32'(n), 32'd20);
        check("cont_done0", 32'(done), 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        check("cont_gap_gnt", 32'(gnt), 32'h0);
        check("cont_gap_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("cont_gnt2", 32'(gnt), 32'h4);
        wait_done(n);
        check("cont_dly2", 32'(n), 32'd20);
        check("cont_done2", 32'(done), 32'h4);
        req = '0;
        @(negedge clk);

        // Zero delay on requester 3
        set_dly(3, 16'd0);
        req = 4'b1000;
        wait_gnt(n);
        check("zero_lat", 32'(n), 32'd1);
        check("zero_gnt", 32'(gnt), 32'h8);
        check("zero_nodone", 32'(done), 32'h0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'h8);
        req = '0;
        @(negedge clk);
        check("zero_busy", 32'(busy), 32'h0);

        // Fairness: requester 1 held, requester 0 re-asserted after each done
        set_dly(0, 16'd1);
        set_dly(1, 16'd1);
        req = 4'b0011;
        for (int g = 0; g < 4; g++) begin
`ifdef MSARB_FIXED_PRIO_EN
            exp_own = 4'b0001;
`else
            exp_own = (g % 2 == 1) ? 4'b0010 : 4'b0001;
`endif
            wait_gnt(n);
            check("fair_lat", 32'(n), 32'd1);
            check("fair_gnt", 32'(gnt), 32'(exp_own));
            wait_done(n);
            check("fair_dly", 32'(n), 32'd10);
            check("fair_done", 32'(done), 32'(exp_own));
            if (exp_own[0]) req[0] = 1'b0;
            if (g == 3) req = '0;
            @(negedge clk);
            check("fair_idle_gnt", 32'(gnt), 32'h0);
            if (g < 3) req[0] = 1'b1;
        end

        // Abort requester 1 with requester 2 pending
        set_dly(1, 16'd5);
        req = 4'b0010;
        wait_gnt(n);
        check("abort_gnt1", 32'(gnt), 32'h2);
        set_dly(2, 16'd1);
        req[2] = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_run_done", 32'(done), 32'h0);
        req[1] = 1'b0;
        @(negedge clk);
        check("abort_gnt_clr", 32'(gnt), 32'h0);
        check("abort_nodone", 32'(done), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("abort_gnt2", 32'(gnt), 32'h4);
        wait_done(n);
        check("abort_dly2", 32'(n), 32'd10);
        req = '0;
        @(negedge clk);

        // Single request, dly=3
        set_dly(0, 16'd3);
        req = 4'b0001;
        wait_gnt(n);
        check("single_lat", 32'(n), 32'd1);
        check("single_gnt", 32'(gnt), 32'h1);
        repeat (8) @(negedge clk);
        check("single_tick_lo", 32'(tick), 32'h0);
        @(negedge clk);
        check("single_tick_hi", 32'(tick), 32'h1);
        wait_done(n);
        check("single_dly", 32'(n + 9), 32'd30);
        check("single_done", 32'(done), 32'h1);
        check("single_done_gnt", 32'(gnt), 32'h1);
        check("single_done_busy", 32'(busy), 32'h1);
        req = '0;
        @(negedge clk);
        check("single_busy_fall", 32'(busy), 32'h0);
        check("single_gnt_fall", 32'(gnt), 32'h0);

        // Reset in mid-run, request held through it
        set_dly(0, 16'd2);
        req = 4'b0001;
        wait_gnt(n);
        check("rst_gnt_pre", 32'(gnt), 32'h1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_gnt(n);
        check("rst_regrant_lat", 32'(n), 32'd1);
        check("rst_regrant", 32'(gnt), 32'h1);
        wait_done(n);
        check("rst_full_dly", 32'(n), 32'd20);
        req = '0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
